// File: rtl/llc_dm_cache_if.sv
// Core-side and memory-side signal bundle for llc_dm_cache.
// Latency: n/a (wires only).
// Backpressure: core side completes with mem_resp_o; memory side uses read/write held until resp_i.
// Ports: mem_* = 256-bit line requests from the core with a byte mask;
//        line_*/address_o/read_o/write_o/resp_i = whole-line traffic to the adaptor.
// master = requester/adaptor environment, slave = the cache.
interface llc_dm_cache_if;
    logic [31:0]  mem_address_i;
    logic         mem_read_i;
    logic         mem_write_i;
    logic [31:0]  mem_wmask_i;
    logic [255:0] mem_wdata_i;
    logic [255:0] mem_rdata_o;
    logic         mem_resp_o;
    logic [255:0] line_o;
    logic [255:0] line_i;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport master (
        output mem_address_i, mem_read_i, mem_write_i, mem_wmask_i, mem_wdata_i,
        output line_i, resp_i,
        input  mem_rdata_o, mem_resp_o, line_o, address_o, read_o, write_o
    );

    modport slave (
        input  mem_address_i, mem_read_i, mem_write_i, mem_wmask_i, mem_wdata_i,
        input  line_i, resp_i,
        output mem_rdata_o, mem_resp_o, line_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/llc_dm_cache.sv
// Direct-mapped write-back/write-allocate last-level cache with hit/miss counters.
// Latency: hit responds 1 cycle after capture; miss adds optional write-back + fill + re-check.
// Backpressure: one request in flight; core inputs ignored from capture until mem_resp_o.
// Ports: clk, reset_n (sync, active-low); bus (slave modport of llc_dm_cache_if);
//        hit_count_o / miss_count_o wrap-around performance counters.
module llc_dm_cache #(
    parameter int SETS = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    llc_dm_cache_if.slave bus,
    output logic [15:0]   hit_count_o,
    output logic [15:0]   miss_count_o
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 27 - IDX;

    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

    state_t state_q, state_d;

    logic [SETS-1:0] valid_q;
    logic [SETS-1:0] dirty_q;
    logic [TAG-1:0]  tag_q  [SETS];
    logic [255:0]    data_q [SETS];

    // Latched request; the line address drops the byte offset entirely.
    logic [26:0]  req_line_q;
    logic         req_write_q;
    logic [31:0]  req_mask_q;
    logic [255:0] req_wdata_q;
    // Set once this request has been filled, so the re-check is not counted as a hit.
    logic         filled_q;

    logic [15:0]  hit_cnt_q;
    logic [15:0]  miss_cnt_q;

    logic [IDX-1:0] idx;
    logic [TAG-1:0] req_tag;
    logic           hit;
    logic           capture;
    logic           wr_hit;
    logic           wb_done;
    logic           fill_done;
    logic           cnt_hit;
    logic           cnt_miss;

    assign idx     = req_line_q[IDX-1:0];
    assign req_tag = req_line_q[26 -: TAG];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
    assign capture = (state_q == IDLE) && (bus.mem_read_i || bus.mem_write_i);

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.mem_resp_o  = 1'b0;
        bus.mem_rdata_o = data_q[idx];
        bus.read_o      = 1'b0;
        bus.write_o     = 1'b0;
        bus.address_o   = '0;
        bus.line_o      = data_q[idx];
        wr_hit          = 1'b0;
        wb_done         = 1'b0;
        fill_done       = 1'b0;
        cnt_hit         = 1'b0;
        cnt_miss        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_read_i || bus.mem_write_i) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (hit) begin
                    bus.mem_resp_o = 1'b1;
                    wr_hit         = req_write_q;
                    cnt_hit        = !filled_q;
                    state_d        = IDLE;
                end else begin
                    cnt_miss = !filled_q;
                    state_d  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                bus.write_o   = 1'b1;
                bus.address_o = {tag_q[idx], idx, 5'b0};
                if (bus.resp_i) begin
                    wb_done = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                bus.read_o    = 1'b1;
                bus.address_o = {req_tag, idx, 5'b0};
                if (bus.resp_i) begin
                    fill_done = 1'b1;
                    state_d   = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state that must come out of reset clean.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            filled_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (capture) begin
                filled_q <= 1'b0;
            end
            if (wr_hit) begin
                dirty_q[idx] <= 1'b1;
            end
            if (wb_done) begin
                dirty_q[idx] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
                filled_q     <= 1'b1;
            end
            if (cnt_hit) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (cnt_miss) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    // Request latch and line storage carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            req_line_q  <= bus.mem_address_i[31:5];
            // Read wins when both strobes are high.
            req_write_q <= bus.mem_write_i && !bus.mem_read_i;
            req_mask_q  <= bus.mem_wmask_i;
            req_wdata_q <= bus.mem_wdata_i;
        end
        if (wr_hit) begin
            for (int b = 0; b < 32; b++) begin
                if (req_mask_q[b]) begin
                    data_q[idx][8*b +: 8] <= req_wdata_q[8*b +: 8];
                end
            end
        end
        if (fill_done) begin
            data_q[idx] <= bus.line_i;
            tag_q[idx]  <= req_tag;
        end
    end
endmodule

// File: tb/tb_llc_dm_cache.sv
// Self-checking bench for llc_dm_cache: directed requests, response scoreboard,
// and a line-memory model that checks every fill/write-back the cache issues.
module tb_llc_dm_cache;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    llc_dm_cache_if bus();

    llc_dm_cache #(.SETS(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .hit_count_o  (hit_cnt),
        .miss_count_o (miss_cnt)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } mem_t;

    logic [255:0] rsp_q[$];
    mem_t         mem_q[$];
    logic [255:0] store [logic [31:0]];

    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'hC0DE_0000 + a + k;
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (store.exists(a)) return store[a];
        return pat(a);
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input bit wr, input logic [31:0] a, input logic [255:0] l);
        mem_t e;
        e.wr = wr;
        e.addr = a;
        e.line = l;
        mem_q.push_back(e);
    endtask

    // Response monitor: every completion pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && bus.mem_resp_o) begin
                if (rsp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL resp_unexpected: got rdata %h with nothing outstanding", bus.mem_rdata_o);
                end else begin
                    check("rdata", bus.mem_rdata_o, rsp_q.pop_front());
                end
            end
        end
    end

    // Adaptor model: answers each fill/write-back 6 cycles after it appears.
    initial begin
        bus.resp_i = 1'b0;
        bus.line_i = '0;
        forever begin
            @(negedge clk);
            if (reset_n && (bus.read_o || bus.write_o)) begin
                mem_t        e;
                logic [31:0] a;
                bit          wr;
                bit          abort;
                abort = 1'b0;
                wr    = bus.write_o;
                a     = bus.address_o;
                if (mem_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL mem_req_unexpected: got wr=%0d addr=%h", wr, a);
                end else begin
                    e = mem_q.pop_front();
                    check("mem_op_is_write", {255'b0, wr}, {255'b0, e.wr});
                    check("mem_addr", {224'b0, a}, {224'b0, e.addr});
                    if (wr) check("wb_line", bus.line_o, e.line);
                end
                if (wr) store[a] = bus.line_o;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (!reset_n) abort = 1'b1;
                    if (!abort) check("mem_req_held", {255'b0, wr ? bus.write_o : bus.read_o}, 256'd1);
                end
                if (!abort) begin
                    bus.line_i = wr ? '0 : mem_line(a);
                    bus.resp_i = 1'b1;
                    @(negedge clk);
                    bus.resp_i = 1'b0;
                    check("mem_req_dropped", {255'b0, wr ? bus.write_o : bus.read_o}, 256'd0);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [31:0] m, input logic [255:0] wd,
                          input logic [255:0] exp_rd, input int exp_lat);
        int n;
        bit seen;
        rsp_q.push_back(exp_rd);
        @(negedge clk);
        bus.mem_address_i = a;
        bus.mem_read_i    = rd;
        bus.mem_write_i   = wr;
        bus.mem_wmask_i   = m;
        bus.mem_wdata_i   = wd;
        @(posedge clk);
        #1;
        bus.mem_read_i  = 1'b0;
        bus.mem_write_i = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.mem_resp_o) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL resp_timeout: addr %h got no mem_resp_o within %0d cycles", a, n);
        end else if (exp_lat > 0) begin
            check("hit_latency", n, exp_lat);
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l40, m40, l240, l640, wd;
        int n;
        bus.mem_address_i = '0;
        bus.mem_read_i    = 1'b0;
        bus.mem_write_i   = 1'b0;
        bus.mem_wmask_i   = '0;
        bus.mem_wdata_i   = '0;

        l40  = pat(32'h40);
        m40  = l40;
        m40[31:0] = 32'hDEADBEEF;
        l240 = pat(32'h240);
        l640 = pat(32'h640);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_resp", {255'b0, bus.mem_resp_o}, 256'd0);
        check("rst_read", {255'b0, bus.read_o}, 256'd0);
        check("rst_write", {255'b0, bus.write_o}, 256'd0);
        check("rst_address", {224'b0, bus.address_o}, 256'd0);
        check("rst_hits", {240'b0, hit_cnt}, 256'd0);
        check("rst_misses", {240'b0, miss_cnt}, 256'd0);
        reset_n = 1'b1;

        // Cold read, then a hit on the same line.
        exp_mem(1'b0, 32'h40, '0);
        do_req(32'h40, 1'b1, 1'b0, '0, '0, l40, 0);
        check("cold_misses", {240'b0, miss_cnt}, 256'd1);
        check("cold_hits", {240'b0, hit_cnt}, 256'd0);
        do_req(32'h40, 1'b1, 1'b0, '0, '0, l40, 1);
        check("hit_hits", {240'b0, hit_cnt}, 256'd1);

        // Masked write: only bytes 0..3 change; response shows the pre-write line.
        wd = {8{32'h5A5A5A5A}};
        wd[31:0] = 32'hDEADBEEF;
        do_req(32'h44, 1'b0, 1'b1, 32'h0000_000F, wd, l40, 1);
        do_req(32'h40, 1'b1, 1'b0, '0, '0, m40, 1);
        check("wr_hits", {240'b0, hit_cnt}, 256'd3);

        // Conflict miss on set 2 evicts the dirty merged line first.
        exp_mem(1'b1, 32'h40, m40);
        exp_mem(1'b0, 32'h240, '0);
        do_req(32'h240, 1'b1, 1'b0, '0, '0, l240, 0);
        check("evict_misses", {240'b0, miss_cnt}, 256'd2);

        // Read and write together behave as a read: data and dirty untouched.
        do_req(32'h240, 1'b1, 1'b1, 32'hFFFF_FFFF, {256{1'b1}}, l240, 1);
        do_req(32'h240, 1'b1, 1'b0, '0, '0, l240, 1);
        check("rw_hits", {240'b0, hit_cnt}, 256'd5);
        exp_mem(1'b0, 32'h40, '0);
        do_req(32'h40, 1'b1, 1'b0, '0, '0, m40, 0);
        check("clean_evict_misses", {240'b0, miss_cnt}, 256'd3);

        // Reset in the middle of a fill.
        exp_mem(1'b0, 32'h640, '0);
        @(negedge clk);
        bus.mem_address_i = 32'h640;
        bus.mem_read_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_read_i = 1'b0;
        n = 0;
        while (!bus.read_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fill_started", {255'b0, bus.read_o}, 256'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_fill_read", {255'b0, bus.read_o}, 256'd0);
        check("rst_fill_misses", {240'b0, miss_cnt}, 256'd0);
        reset_n = 1'b1;
        @(negedge clk);
        exp_mem(1'b0, 32'h640, '0);
        do_req(32'h640, 1'b1, 1'b0, '0, '0, l640, 0);
        check("reread_misses", {240'b0, miss_cnt}, 256'd1);
        do_req(32'h640, 1'b1, 1'b0, '0, '0, l640, 1);
        check("reread_hits", {240'b0, hit_cnt}, 256'd1);

        // Hit counter wrap from 0xFFFF.
        force dut.hit_cnt_q = 16'hFFFF;
        #1;
        release dut.hit_cnt_q;
        @(negedge clk);
        check("preload_hits", {240'b0, hit_cnt}, 256'hFFFF);
        do_req(32'h640, 1'b1, 1'b0, '0, '0, l640, 1);
        check("wrap_hits", {240'b0, hit_cnt}, 256'd0);
        check("wrap_misses", {240'b0, miss_cnt}, 256'd1);

        repeat (20) @(negedge clk);
        check("rsp_q_drained", rsp_q.size(), 256'd0);
        check("mem_q_drained", mem_q.size(), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
